// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: data bus width, op and state encodings.
// Optional build macro MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

package mdu_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_WB   = 2'd3
   } mdu_state_e;

   // Accumulate ops only count as real requests when the accumulate datapath is built.
   function automatic logic op_supported(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_signed(input logic [3:0] op);
      case (op)
         OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_mul(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider on operand magnitudes: 32 iterations, one per clock,
// with signs re-applied combinationally on the final step (done_o).
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module mdu_div_iter
   import mdu_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic            signed_i,
   input  logic [`DATA_BUS] dividend_i,
   input  logic [`DATA_BUS] divisor_i,
   output logic [`DATA_BUS] quotient_o,
   output logic [`DATA_BUS] remainder_o,
   output logic            done_o
);

   logic              run_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [`DATA_BUS]  rem_q;
   logic [`DATA_BUS]  quo_q;
   logic [`DATA_BUS]  dvs_q;
   logic              q_neg_q;
   logic              r_neg_q;

   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   diff;
   logic [`DATA_BUS]  rem_step;
   logic [`DATA_BUS]  quo_step;
   logic [`DATA_BUS]  dividend_mag;
   logic [`DATA_BUS]  divisor_mag;

   assign dividend_mag = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
   assign divisor_mag  = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

   // A zero divisor never fails the trial subtract, so the quotient fills with ones
   // and the remainder ends up holding the whole dividend magnitude.
   always_comb begin
      // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
      rem_sh   = {rem_q, quo_q[DATA_W-1]};
      diff     = rem_sh - {1'b0, dvs_q};
      rem_step = rem_sh[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], 1'b0};
      if (!diff[DATA_W]) begin
         rem_step    = diff[DATA_W-1:0];
         quo_step[0] = 1'b1;
      end
   end

   assign quotient_o  = q_neg_q ? -quo_step : quo_step;
   assign remainder_o = r_neg_q ? -rem_step : rem_step;
   assign done_o      = run_q && (cnt_q == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (abort_i) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start_i) begin
         run_q   <= 1'b1;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= dividend_mag;
         dvs_q   <= divisor_mag;
         q_neg_q <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
         r_neg_q <= signed_i && dividend_i[DATA_W-1];
      end else if (run_q) begin
         rem_q <= rem_step;
         quo_q <= quo_step;
         if (done_o) begin
            run_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: IDLE/MUL/DIV/WB sequencing and HILO write-back.
// Define MDU_MADD_EN to build the 64-bit accumulate path for ops 7..10.
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module mdu_ctrl
   import mdu_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [`DATA_BUS] src_a_i,
   input  logic [`DATA_BUS] src_b_i,
   input  logic [`DATA_BUS] hi_i,
   input  logic [`DATA_BUS] lo_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            hilo_we,
   output logic [`DATA_BUS] hi_o,
   output logic [`DATA_BUS] lo_o
);

   mdu_state_e          state_q, state_d;
   logic [3:0]          op_q, op_d;
   logic [`DATA_BUS]    a_q, a_d;
   logic [`DATA_BUS]    b_q, b_d;
   logic [2*DATA_W-1:0] res_q, res_d;
   logic [`DATA_BUS]    last_hi_q, last_lo_q;

   logic                accept;
   logic                div_start;
   logic                div_done;
   logic [`DATA_BUS]    div_quo;
   logic [`DATA_BUS]    div_rem;
   logic                mul_signed;
   logic [2*DATA_W-1:0] ext_a;
   logic [2*DATA_W-1:0] ext_b;
   logic [2*DATA_W-1:0] product;
   logic [2*DATA_W-1:0] mul_res;

   mdu_div_iter u_div (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start),
      .abort_i     (flush_i),
      .signed_i    (op_is_signed(op_i)),
      .dividend_i  (src_a_i),
      .divisor_i   (src_b_i),
      .quotient_o  (div_quo),
      .remainder_o (div_rem),
      .done_o      (div_done)
   );

   // Sign-extending to 64 bits lets one truncated multiply serve both signednesses.
   assign mul_signed = op_is_signed(op_q);
   assign ext_a      = {{DATA_W{mul_signed & a_q[DATA_W-1]}}, a_q};
   assign ext_b      = {{DATA_W{mul_signed & b_q[DATA_W-1]}}, b_q};
   assign product    = ext_a * ext_b;

`ifdef MDU_MADD_EN
   // res_q holds the {hi,lo} captured on accept, which is the accumulate base.
   always_comb begin
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = res_q + product;
         OP_MSUB, OP_MSUBU: mul_res = res_q - product;
         default:           mul_res = product;
      endcase
   end
`else
   assign mul_res = product;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      accept    = 1'b0;
      div_start = 1'b0;
      stall_o   = 1'b0;
      hilo_we   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && op_supported(op_i) && !flush_i) begin
               accept  = 1'b1;
               stall_o = 1'b1;
               op_d    = op_i;
               a_d     = src_a_i;
               b_d     = src_b_i;
               res_d   = {hi_i, lo_i};
               if (op_is_mul(op_i)) begin
                  state_d = ST_MUL;
               end else if (op_i == OP_DIV || op_i == OP_DIVU) begin
                  state_d   = ST_DIV;
                  div_start = 1'b1;
               end else begin
                  state_d = ST_WB;
                  if (op_i == OP_MTHI) res_d[2*DATA_W-1:DATA_W] = src_a_i;
                  else                 res_d[DATA_W-1:0]        = src_a_i;
               end
            end
         end
         ST_MUL: begin
            stall_o = 1'b1;
            res_d   = mul_res;
            state_d = ST_WB;
         end
         ST_DIV: begin
            stall_o = 1'b1;
            if (div_done) begin
               res_d   = {div_rem, div_quo};
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            hilo_we = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Flush wins over everything; keeping res_q stops a half-done result leaking out.
      if (flush_i) begin
         state_d = ST_IDLE;
         hilo_we = 1'b0;
         res_d   = res_q;
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign hi_o   = hilo_we ? res_q[2*DATA_W-1:DATA_W] : last_hi_q;
   assign lo_o   = hilo_we ? res_q[DATA_W-1:0]        : last_lo_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_NOP;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         last_hi_q <= '0;
         last_lo_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         if (hilo_we) begin
            last_hi_q <= res_q[2*DATA_W-1:DATA_W];
            last_lo_q <= res_q[DATA_W-1:0];
         end
      end
   end

endmodule
